// File: rtl/key_pkg.sv
// key_pkg: shared state encoding and debounce-length helper for key_debounce.
`default_nettype none

package key_pkg;

    typedef enum logic [1:0] {
        UP      = 2'd0,
        WAIT_DN = 2'd1,
        DN      = 2'd2,
        WAIT_UP = 2'd3
    } key_state_t;

    function automatic longint unsigned db_cycles(input longint unsigned clk_hz,
                                                  input longint unsigned ms);
        longint unsigned c;
        c = clk_hz / 1000 * ms;
        return (c < 1) ? 64'd1 : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_sync.sv
// key_sync: two-flop synchroniser with optional inversion; resets to 0.
`default_nettype none

module key_sync #(
    parameter bit INV = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic s0;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0   <= 1'b0;
            dout <= 1'b0;
        end else begin
            s0   <= din ^ INV;
            dout <= s0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/key_debounce.sv
// key_debounce: synchronised, debounced push-button with press/release strobes and TBUF enable.
// Build option KEY_TOGGLE_EN: oen_o toggles on each press instead of following the held level.
`default_nettype none

module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 27_000_000,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter bit          INV         = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic key_o,
    output logic press_o,
    output logic release_o,
    output logic oen_o
);

    localparam longint unsigned DB_CYC  = db_cycles(64'(CLK_HZ), 64'(DEBOUNCE_MS));
    localparam int              CW      = $clog2(DB_CYC + 1);
    localparam bit              ONE_CYC = (DB_CYC == 1);
    // The first differing sample is seen in UP/DN, so cnt tracks the remaining DB_CYC-1 samples.
    localparam logic [CW-1:0]   LAST    = (DB_CYC >= 2) ? CW'(DB_CYC - 2) : '0;

    logic       s1;
    key_state_t state;
    logic [CW-1:0] cnt;
    logic       rise;
    logic       fall;

    key_sync #(.INV(INV)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (key_i),
        .dout (s1)
    );

    always_comb begin
        rise = 1'b0;
        fall = 1'b0;
        case (state)
            UP:      rise = s1 && ONE_CYC;
            WAIT_DN: rise = s1 && (cnt == LAST);
            DN:      fall = !s1 && ONE_CYC;
            WAIT_UP: fall = !s1 && (cnt == LAST);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= UP;
            cnt       <= '0;
            key_o     <= 1'b0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
        end else begin
            press_o   <= rise;
            release_o <= fall;
            if (rise) begin
                state <= DN;
                key_o <= 1'b1;
            end else if (fall) begin
                state <= UP;
                key_o <= 1'b0;
            end else begin
                case (state)
                    UP: if (s1) begin
                        state <= WAIT_DN;
                        cnt   <= '0;
                    end
                    WAIT_DN: if (!s1) state <= UP;
                             else     cnt   <= cnt + 1'b1;
                    DN: if (!s1) begin
                        state <= WAIT_UP;
                        cnt   <= '0;
                    end
                    WAIT_UP: if (s1) state <= DN;
                             else    cnt   <= cnt + 1'b1;
                    default: state <= UP;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            oen_o <= 1'b1;
        end else begin
`ifdef KEY_TOGGLE_EN
            if (rise) oen_o <= ~oen_o;
`else
            if (rise)      oen_o <= 1'b0;
            else if (fall) oen_o <= 1'b1;
`endif
        end
    end

endmodule

`default_nettype wire
